data_memory_bytelane: RTL
=========================

Name: data_memory_bytelane

Overview:
- Parametrised RV32I data memory for the single-cycle/pipelined core.
- Supports byte, half and word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3.
- Byte-lane write enables; read data is sign- or zero-extended.
- Read latency is configurable and reported with a valid pulse; misaligned accesses are detected and suppressed.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2, ≥ 4.
- READ_LAT, 1, load latency in cycles from request to rvalid; legal values 1 or 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req  in  1  access request this cycle.
- WE  in  1  1 = store, 0 = load; qualified by req.
- A  in  32  byte address.
- WD  in  32  store data; the low byte/half/word is used per funct3.
- funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
- RD  out  32  extended load data; valid when rvalid = 1.
- rvalid  out  1  one-cycle pulse per completed load.
- misalign  out  1  one-cycle pulse, same cycle the access would have completed.

Behaviour:
- Reset:
  - RD = 0, rvalid = 0, misalign = 0, read pipeline cleared.
  - Memory array is not reset.
  - Reset asserted mid-operation cancels any in-flight load; no rvalid follows.
- Indexing:
  - word index = A[log2(DEPTH_WORDS)+1 : 2].
  - Upper address bits are ignored, so accesses wrap modulo 4*DEPTH_WORDS bytes.
- Alignment:
  - H/HU require A[0] = 0.
  - W requires A[1:0] = 00.
  - Illegal funct3 is treated as misaligned.
- Store (req & WE):
  - Written at the clk edge of the request cycle.
  - Byte lanes: SB writes lane A[1:0] with WD[7:0]; SH writes lanes {A[1],0} and {A[1],1} with WD[15:0]; SW writes all four lanes.
  - No rvalid.
  - If misaligned: no lane written; misalign pulses the next cycle.
- Load (req & !WE):
  - Array read is registered.
  - Lane extraction and extension happen in the output stage.
  - rvalid and RD are asserted exactly READ_LAT cycles after the request cycle.
  - B/H sign-extend; BU/HU zero-extend.
  - If misaligned: RD = 0, rvalid = 0, misalign = 1 at the same latency.
- Pipelining:
  - One request per cycle; back-to-back loads are accepted every cycle.
  - Responses return in order.
- Read/write ordering:
  - A store followed by a load to the same word in the next cycle returns the new data.
  - Only one request per cycle, so there is no same-cycle read/write conflict.
- Holding:
  - RD holds its last valid value when rvalid = 0.
  - The exception is a misaligned load, which forces RD = 0.
- req = 0: no array activity; rvalid and misalign stay 0 for that slot.

Optional Feature:
- Macro: DMEM_ERR_CNT_EN.
- When defined:
  - Adds output port err_cnt (16 bits): a saturating count of misalign pulses.
  - Cleared by rst; holds at 16'hFFFF once reached.
  - When a misalign pulse and rst coincide, rst wins.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- SW A=0x10 WD=0xDEADBEEF, then LW A=0x10 → RD=0xDEADBEEF, rvalid after READ_LAT cycles.
- SB A=0x13 WD=0x80, then LB A=0x13 → RD=0xFFFFFF80; LBU A=0x13 → RD=0x00000080; LW A=0x10 → RD=0x80ADBEEF.
- SH A=0x12 WD=0x1234, then LH A=0x12 → RD=0x00001234; LHU A=0x10 → RD=0x0000BEEF.
- LW A=0x11 → misalign=1, rvalid=0, RD=0; SH A=0x15 → no word changed, misalign=1; with DMEM_ERR_CNT_EN, err_cnt=2.
- Back-to-back LW at 0x0, 0x4, 0x8 in consecutive cycles → three consecutive rvalid pulses, data in order; repeat with READ_LAT=2.
- LW issued, rst asserted the next cycle → no rvalid, RD=0; with DEPTH_WORDS=1024, SW A=0x1000 overwrites word 0 (wrap).

Source files
------------

// File: rtl/data_memory_bytelane.sv
// -----------------------------------------------------------------------------
// data_memory_bytelane
//
// RV32I data memory with byte-lane write enables, sign/zero-extending loads,
// misalignment detection and a configurable load latency (1 or 2 cycles).
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of 2, >= 4). Addresses wrap
//                 modulo 4*DEPTH_WORDS bytes.
//   READ_LAT    : cycles from load request to rvalid (1 or 2).
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   req      in   access request this cycle
//   WE       in   1 = store, 0 = load (qualified by req)
//   A        in   [31:0] byte address
//   WD       in   [31:0] store data (low byte/half/word used per funct3)
//   funct3   in   [2:0] 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//   RD       out  [31:0] extended load data, valid while rvalid = 1
//   rvalid   out  one-cycle pulse per completed load
//   misalign out  one-cycle pulse when a misaligned/illegal access would
//                 have completed (next cycle for stores, READ_LAT for loads)
//   err_cnt  out  [15:0] saturating misalign pulse count
//                 (present only when DMEM_ERR_CNT_EN is defined)
//
// Optional feature macro: DMEM_ERR_CNT_EN
// -----------------------------------------------------------------------------
module data_memory_bytelane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [2:0]  funct3,
  output logic [31:0] RD,
  output logic        rvalid,
  output logic        misalign
`ifdef DMEM_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] w_idx;
  logic          w_misal;
  logic          w_ld_ok;
  logic          w_st_ok;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;

  // Address bits above the array index are deliberately ignored (wrap).
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, A[31:AW+2]};

  assign w_idx = A[AW+1:2];

  // Illegal funct3 codes are reported exactly like a misaligned access.
  always_comb begin
    w_misal = 1'b0;
    case (funct3)
      3'b000, 3'b100: w_misal = 1'b0;
      3'b001, 3'b101: w_misal = A[0];
      3'b010:         w_misal = |A[1:0];
      default:        w_misal = 1'b1;
    endcase
  end

  assign w_ld_ok = req & ~WE & ~w_misal;
  assign w_st_ok = req &  WE & ~w_misal;

  // Lane enables and lane-replicated write data: each lane simply takes its
  // own byte of w_wdata, so no per-lane muxing is needed.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WD;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << A[1:0];
        w_wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        w_be    = A[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WD[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = WD;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = WD;
      end
    endcase
    if (!w_st_ok) begin
      w_be = 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide array per lane, write-enable per lane, registered
  // read. Only one request per cycle, so read and write never collide.
  // ---------------------------------------------------------------------------
  logic [31:0] w_s1_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rdata;

      always_ff @(posedge clk) begin
        if (w_be[gi]) begin
          r_mem[w_idx] <= w_wdata[gi*8 +: 8];
        end
        if (w_ld_ok) begin
          r_rdata <= r_mem[w_idx];
        end
      end

      assign w_s1_word[gi*8 +: 8] = r_rdata;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1 control (travels alongside the registered array read)
  // ---------------------------------------------------------------------------
  logic       r_s1_ld;
  logic       r_s1_ldmis;
  logic       r_s1_stmis;
  logic [2:0] r_s1_f3;
  logic [1:0] r_s1_off;

  always_ff @(posedge clk) begin
    r_s1_f3  <= funct3;
    r_s1_off <= A[1:0];
    if (rst) begin
      r_s1_ld    <= 1'b0;
      r_s1_ldmis <= 1'b0;
      r_s1_stmis <= 1'b0;
    end else begin
      r_s1_ld    <= w_ld_ok;
      r_s1_ldmis <= req & ~WE & w_misal;
      r_s1_stmis <= req &  WE & w_misal;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional second stage for READ_LAT = 2. Store misalignment is always
  // reported one cycle after the request, so it is taken from stage 1.
  // ---------------------------------------------------------------------------
  logic [31:0] w_fin_word;
  logic        w_fin_ld;
  logic        w_fin_ldmis;
  logic [2:0]  w_fin_f3;
  logic [1:0]  w_fin_off;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [31:0] r_s2_word;
      logic        r_s2_ld;
      logic        r_s2_ldmis;
      logic [2:0]  r_s2_f3;
      logic [1:0]  r_s2_off;

      always_ff @(posedge clk) begin
        r_s2_word <= w_s1_word;
        r_s2_f3   <= r_s1_f3;
        r_s2_off  <= r_s1_off;
        if (rst) begin
          r_s2_ld    <= 1'b0;
          r_s2_ldmis <= 1'b0;
        end else begin
          r_s2_ld    <= r_s1_ld;
          r_s2_ldmis <= r_s1_ldmis;
        end
      end

      assign w_fin_word  = r_s2_word;
      assign w_fin_ld    = r_s2_ld;
      assign w_fin_ldmis = r_s2_ldmis;
      assign w_fin_f3    = r_s2_f3;
      assign w_fin_off   = r_s2_off;
    end else begin : g_lat1
      assign w_fin_word  = w_s1_word;
      assign w_fin_ld    = r_s1_ld;
      assign w_fin_ldmis = r_s1_ldmis;
      assign w_fin_f3    = r_s1_f3;
      assign w_fin_off   = r_s1_off;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output stage: lane extraction and sign/zero extension
  // ---------------------------------------------------------------------------
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_shift = w_fin_word >> {w_fin_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_fin_off[1] ? w_fin_word[31:16] : w_fin_word[15:0];

  always_comb begin
    w_ext = 32'd0;
    case (w_fin_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      3'b010:  w_ext = w_fin_word;
      default: w_ext = 32'd0;
    endcase
  end

  // RD holds the last returned value between loads; a misaligned load clears it.
  logic [31:0] r_rd_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_hold <= 32'd0;
    end else if (w_fin_ld) begin
      r_rd_hold <= w_ext;
    end else if (w_fin_ldmis) begin
      r_rd_hold <= 32'd0;
    end
  end

  // Outputs are masked while rst is high so that a load completing in the
  // reset cycle itself is cancelled as well.
  always_comb begin
    RD       = r_rd_hold;
    rvalid   = w_fin_ld;
    misalign = w_fin_ldmis | r_s1_stmis;
    if (w_fin_ld) begin
      RD = w_ext;
    end else if (w_fin_ldmis) begin
      RD = 32'd0;
    end
    if (rst) begin
      RD       = 32'd0;
      rvalid   = 1'b0;
      misalign = 1'b0;
    end
  end

`ifdef DMEM_ERR_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating misalignment counter (reset has priority over a pulse)
  // ---------------------------------------------------------------------------
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 16'd0;
    end else if (misalign && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
